fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch stage with a decoupling queue, the successor to the fixed single-register fetch path (PC register, PC+4 adder, IF/ID register). Each cycle it drives the PC to instruction memory and pushes the returned instruction and its PC+4 into a DEPTH-entry FIFO. Decode drains the FIFO through a valid/ready handshake. A redirect from EX (taken branch, jump, jr) flushes the queue and reloads the PC. It sits between the PC/instruction memory and the ID stage.

---
 rtl/fetch_queue_unit.sv | 105 ++++++++++
 tb/tb_fetch_queue_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction fetch with a DEPTH-entry decoupling queue; a fetch pushed at edge N reaches decode in cycle N+1.
// A redirect flushes the queue and refetches from the target next cycle. A full queue stops fetch until decode pops.
module fetch_queue_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [ADDR_W-1:0]          imem_addr,
  output logic                       imem_req,
  input  logic [INST_W-1:0]          imem_rdata,
  input  logic                       imem_ready,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [INST_W-1:0]          dec_inst,
  output logic [ADDR_W-1:0]          dec_pc_4,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       misalign
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              misalign_q, misalign_d;

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc4_mem  [DEPTH];

  logic              pop, push, can_push;
  logic [ADDR_W-1:0] pc_plus4;

  assign pc_plus4  = pc_q + ADDR_W'(4);
  assign dec_valid = (count_q != '0) & ~redirect_valid;
  assign pop       = dec_valid & dec_ready;
  // A pop in the same cycle frees the slot, so full-queue streaming keeps 1 IPC.
  assign can_push  = (count_q < DEPTH_C) | pop;
  assign imem_req  = rst_n & ~redirect_valid & can_push;
  assign push      = imem_req & imem_ready;

  assign imem_addr = pc_q;
  assign dec_inst  = inst_mem[rd_ptr_q];
  assign dec_pc_4  = pc4_mem[rd_ptr_q];
  assign q_count   = count_q;
  assign misalign  = misalign_q;

  always_comb begin
    pc_d       = pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[ADDR_W-1:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
    end else begin
      if (push) begin
        pc_d     = pc_plus4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Payload storage is deliberately unreset; it is only observed when count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= imem_rdata;
      pc4_mem[wr_ptr_q]  <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc_4;
  logic [2:0]  q_count;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  ent_t        sb[$];
  logic [31:0] m_pc  = 32'h0;
  logic        m_mis = 1'b0;

  fetch_queue_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc_4       (dec_pc_4),
    .q_count        (q_count),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = memf(imem_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: checks outputs for the current cycle, then advances to the next edge.
  always @(negedge clk) begin
    logic exp_req, exp_dv;
    if (!rst_n) begin
      sb.delete();
      m_pc  = 32'h0;
      m_mis = 1'b0;
      chk("rst_addr", 64'(imem_addr), 64'(32'h0));
      chk("rst_req", 64'(imem_req), 64'(1'b0));
      chk("rst_dvalid", 64'(dec_valid), 64'(1'b0));
      chk("rst_count", 64'(q_count), 64'(0));
      chk("rst_misalign", 64'(misalign), 64'(1'b0));
    end else begin
      exp_dv  = (sb.size() != 0) && !redirect_valid;
      exp_req = !redirect_valid && ((sb.size() < DEPTH) || (exp_dv && dec_ready));
      chk("addr", 64'(imem_addr), 64'(m_pc));
      chk("req", 64'(imem_req), 64'(exp_req));
      chk("dvalid", 64'(dec_valid), 64'(exp_dv));
      chk("count", 64'(q_count), 64'(sb.size()));
      chk("misalign", 64'(misalign), 64'(m_mis));
      if (exp_dv) begin
        chk("pc4", 64'(dec_pc_4), 64'(sb[0].pc4));
        chk("inst", 64'(dec_inst), 64'(sb[0].inst));
      end
      if (redirect_valid) begin
        sb.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
      end else begin
        if (exp_dv && dec_ready) void'(sb.pop_front());
        if (exp_req && imem_ready) begin
          sb.push_back('{pc4: m_pc + 32'd4, inst: memf(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_ready     = 1'b1;
    dec_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step(2);

    // Streaming from reset.
    rst_n = 1'b1;
    step(10);

    // Decode stall from reset fills the queue then stops fetch.
    rst_n = 1'b0; dec_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(6);
    @(negedge clk); #1;
    chk("full_count", 64'(q_count), 64'(4));
    chk("full_req", 64'(imem_req), 64'(1'b0));
    chk("full_addr", 64'(imem_addr), 64'(32'h10));
    chk("full_head", 64'(dec_pc_4), 64'(32'h4));

    // Release decode while full: push and pop every cycle.
    @(posedge clk); #1;
    dec_ready = 1'b1;
    step(12);

    // Build three entries, then redirect to 0x100.
    dec_ready = 1'b0;
    redirect(32'h200);
    step(3);
    dec_ready = 1'b1;
    redirect(32'h100);
    step(3);

    // Memory stall pattern 1,0,0,1.
    imem_ready = 1'b1; step(1);
    imem_ready = 1'b0; step(2);
    imem_ready = 1'b1; step(1);
    step(3);

    // Misaligned redirect is sticky across later aligned redirects.
    redirect(32'h102);
    step(2);
    redirect(32'h300);
    step(2);
    @(negedge clk); #1;
    chk("mis_sticky", 64'(misalign), 64'(1'b1));

    // PC wrap at the top of the address space.
    @(posedge clk); #1;
    redirect(32'hFFFF_FFF8);
    step(5);

    // Randomised traffic with occasional redirects.
    for (int i = 0; i < 300; i++) begin
      imem_ready     = ($urandom_range(3) != 0);
      dec_ready      = ($urandom_range(2) != 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = $urandom;
      step(1);
    end
    redirect_valid = 1'b0;

    // Reset mid-operation clears queue, PC and the sticky flag.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
